// File: rtl/char_pkg.sv
// char_pkg: shared types and constants for the character movement controller.
//   COORD_W      default coordinate width (position and ground level)
//   char_state_e vertical motion state: GROUND, RISE, FALL
//   vel_t        signed vertical velocity (positive = downward)
package char_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } char_state_e;

    // Two guard bits over the coordinate width. Velocities stay within
    // +/-max(JUMP_V, VMAX_FALL), so this is wide enough even when a
    // module instance overrides its own coordinate width.
    typedef logic signed [COORD_W+1:0] vel_t;

endpackage

// File: rtl/char_vert_phys.sv
// char_vert_phys: vertical motion of the character, advanced once per enabled
// cycle (one frame). Owns the GROUND/RISE/FALL state machine, the vertical
// velocity, the jump counter, landing, ceiling and ledge handling.
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   en            frame strobe; nothing changes on cycles where it is low
//   jump_req      jump edge already detected by the caller for this frame
//   ground_y      floor surface Y under the character
//   pos_y         registered sprite top Y
//   jump_cnt      jumps used since the character last stood on ground
//   on_ground     high while in GROUND
//   state         current state, exported for observation
//
// Valid/ready: none. en is a qualifier only; every enabled cycle is
// consumed, and results are visible on the registered outputs one cycle
// after the enabling edge.
module char_vert_phys
    import char_pkg::*;
#(
    parameter int COORD_W   = char_pkg::COORD_W,
    parameter int CHAR_H    = 64,
    parameter int START_Y   = 536,
    parameter int JUMP_V    = 16,
    parameter int GRAVITY   = 1,
    parameter int VMAX_FALL = 20,
    parameter int MAX_JUMPS = 2,
    parameter int JC_W      = $clog2(MAX_JUMPS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               jump_req,
    input  logic [COORD_W-1:0] ground_y,
    output logic [COORD_W-1:0] pos_y,
    output logic [JC_W-1:0]    jump_cnt,
    output logic               on_ground,
    output char_state_e        state
);

    localparam int SW = COORD_W + 2;
    typedef logic signed [SW-1:0] sw_t;

    localparam sw_t ZERO   = sw_t'(0);
    localparam sw_t H_S    = sw_t'(CHAR_H);
    localparam sw_t G_S    = sw_t'(GRAVITY);
    localparam sw_t VMAX_S = sw_t'(VMAX_FALL);

    char_state_e        state_q, state_d;
    vel_t               vy_q, vy_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [JC_W-1:0]    jc_q, jc_d;

    // Signed working copies of the current frame's values.
    sw_t y_s, vy_s, gnd_s, gnd_top_s, y_bot_s, y_next_s, vy_inc_s;
    logic jump_ok;

    always_comb begin
        y_s       = sw_t'({2'b00, pos_y_q});
        vy_s      = sw_t'(vy_q);
        gnd_s     = sw_t'({2'b00, ground_y});
        gnd_top_s = gnd_s - H_S;
        y_bot_s   = y_s + H_S;
        y_next_s  = y_s + vy_s;
        vy_inc_s  = vy_s + G_S;
        if (vy_inc_s > VMAX_S) begin
            vy_inc_s = VMAX_S;
        end
        jump_ok   = jump_req && (jc_q < JC_W'(MAX_JUMPS));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GROUND;
            vy_q    <= '0;
            pos_y_q <= COORD_W'(START_Y);
            jc_q    <= '0;
        end else begin
            state_q <= state_d;
            vy_q    <= vy_d;
            pos_y_q <= pos_y_d;
            jc_q    <= jc_d;
        end
    end

    // Next-state logic. A jump wins over everything else in a frame and
    // leaves pos_y untouched; the new velocity is first applied next frame.
    always_comb begin
        state_d = state_q;
        vy_d    = vy_q;
        pos_y_d = pos_y_q;
        jc_d    = jc_q;
        if (en) begin
            if (jump_ok) begin
                vy_d    = vel_t'(-JUMP_V);
                jc_d    = jc_q + JC_W'(1);
                state_d = RISE;
            end else begin
                case (state_q)
                    GROUND: begin
                        if (y_bot_s < gnd_s) begin
                            // Walked off a ledge: drop with zero velocity,
                            // jump_cnt stays 0 so an air jump remains.
                            state_d = FALL;
                            vy_d    = '0;
                        end else if (y_bot_s > gnd_s) begin
                            pos_y_d = COORD_W'(gnd_top_s);
                        end
                    end
                    RISE, FALL: begin
                        // Landing and ceiling look ahead at pos_y + vy and
                        // replace the ordinary integration step.
                        if (vy_s > ZERO && (y_next_s + H_S) >= gnd_s) begin
                            pos_y_d = COORD_W'(gnd_top_s);
                            vy_d    = '0;
                            jc_d    = '0;
                            state_d = GROUND;
                        end else if (y_next_s < ZERO) begin
                            pos_y_d = '0;
                            vy_d    = '0;
                            state_d = FALL;
                        end else begin
                            pos_y_d = COORD_W'(y_next_s);
                            vy_d    = vel_t'(vy_inc_s);
                            if (state_q == RISE && vy_inc_s >= ZERO) begin
                                state_d = FALL;
                            end
                        end
                    end
                    default: begin
                        state_d = FALL;
                        vy_d    = '0;
                    end
                endcase
            end
        end
    end

    // Outputs, all taken straight from registers.
    always_comb begin
        pos_y     = pos_y_q;
        jump_cnt  = jc_q;
        on_ground = (state_q == GROUND);
        state     = state_q;
    end

endmodule

// File: rtl/char_motion.sv
// char_motion: per-frame character movement controller. Integrates walking
// left/right with playfield clamping, detects jump key edges and delegates
// vertical motion to char_vert_phys.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   frame_tick                   one-cycle frame pulse; all updates happen here
//   stepleft/stepright/stepjump  level-sensitive movement requests
//   ground_y                     floor surface Y under the character
//   pos_x, pos_y                 registered sprite top-left corner
//   flip_h                       1 = facing left
//   on_ground                    high while standing on ground
//   jump_cnt                     jumps used since last touching ground
//   state_dbg                    vertical state machine state
//
// Valid/ready: none. frame_tick is a strobe that is always accepted; its
// effect appears on the registered outputs one cycle later.
module char_motion
    import char_pkg::*;
#(
    parameter int COORD_W   = char_pkg::COORD_W,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 1023,
    parameter int CHAR_W    = 48,
    parameter int CHAR_H    = 64,
    parameter int START_X   = 100,
    parameter int START_Y   = 536,
    parameter int STEP_X    = 4,
    parameter int JUMP_V    = 16,
    parameter int GRAVITY   = 1,
    parameter int VMAX_FALL = 20,
    parameter int MAX_JUMPS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_tick,
    input  logic                             stepleft,
    input  logic                             stepright,
    input  logic                             stepjump,
    input  logic [COORD_W-1:0]               ground_y,
    output logic [COORD_W-1:0]               pos_x,
    output logic [COORD_W-1:0]               pos_y,
    output logic                             flip_h,
    output logic                             on_ground,
    output logic [$clog2(MAX_JUMPS+1)-1:0]   jump_cnt,
    output char_state_e                      state_dbg
);

    localparam int JC_W = $clog2(MAX_JUMPS + 1);
    localparam int SW   = COORD_W + 2;
    typedef logic signed [SW-1:0] sw_t;

    localparam sw_t X_LO = sw_t'(X_MIN);
    localparam sw_t X_HI = sw_t'(X_MAX - CHAR_W);

    logic [COORD_W-1:0] pos_x_q;
    logic               flip_q;
    logic               jump_ref_q;
    logic               armed_q;

    logic tick_en;
    logic jump_edge;
    sw_t  x_cur, x_new;
    logic flip_d;

    // armed_q is low for the first edge after reset release, so a tick
    // coinciding with that release is dropped.
    assign tick_en   = frame_tick && armed_q;
    assign jump_edge = stepjump && !jump_ref_q;

    always_comb begin
        x_cur  = sw_t'({2'b00, pos_x_q});
        x_new  = x_cur;
        flip_d = flip_q;
        if (stepleft && !stepright) begin
            x_new  = x_cur - sw_t'(STEP_X);
            flip_d = 1'b1;
        end else if (stepright && !stepleft) begin
            x_new  = x_cur + sw_t'(STEP_X);
            flip_d = 1'b0;
        end
        if (x_new < X_LO) begin
            x_new = X_LO;
        end else if (x_new > X_HI) begin
            x_new = X_HI;
        end
    end

    // The jump reference resets to 1 so a key held through reset does not
    // count as a fresh press; it only follows stepjump on frame ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x_q    <= COORD_W'(START_X);
            flip_q     <= 1'b0;
            jump_ref_q <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (tick_en) begin
                pos_x_q    <= COORD_W'(x_new);
                flip_q     <= flip_d;
                jump_ref_q <= stepjump;
            end
        end
    end

    char_vert_phys #(
        .COORD_W   (COORD_W),
        .CHAR_H    (CHAR_H),
        .START_Y   (START_Y),
        .JUMP_V    (JUMP_V),
        .GRAVITY   (GRAVITY),
        .VMAX_FALL (VMAX_FALL),
        .MAX_JUMPS (MAX_JUMPS),
        .JC_W      (JC_W)
    ) u_vert (
        .clk       (clk),
        .rst       (rst),
        .en        (tick_en),
        .jump_req  (jump_edge),
        .ground_y  (ground_y),
        .pos_y     (pos_y),
        .jump_cnt  (jump_cnt),
        .on_ground (on_ground),
        .state     (state_dbg)
    );

    assign pos_x  = pos_x_q;
    assign flip_h = flip_q;

endmodule
